// File: rtl/serv_mem_arb.sv
// ---------------------------------------------------------------------------
// serv_mem_arb
//
// Shares one Wishbone-style memory bus between the SERV instruction fetch
// port (ibus) and the load/store port (dbus).
//
// Arbitration:
//   * A single request from IDLE is granted on the next cycle.
//   * Two simultaneous requests from IDLE go to the master that was NOT
//     granted most recently. After reset dbus counts as the last winner, so
//     ibus wins the first tie.
//   * Every transaction ends in IDLE, so back-to-back transactions always
//     have one dead cycle between them.
//
// Termination:
//   * Bus ack: the granted master sees its ack in the same cycle as i_wb_ack.
//   * Abort: the granted master drops cyc; the arbiter returns to IDLE.
//   * Timeout: after TIMEOUT granted cycles without i_wb_ack the master is
//     acked with zero read data, and o_timeout pulses. A bus ack arriving on
//     the expiry cycle wins, and no o_timeout is raised. TIMEOUT = 0 disables
//     the timeout.
//
// Parameters:
//   RESET_STRATEGY  "MINI" (default) or "NONE". Only the read-data return
//                   paths are exempt under "NONE", and they hold no state, so
//                   every state element is reset under both strategies.
//   TIMEOUT         granted cycles allowed before a forced ack (0 = off).
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_ibus_adr/cyc            fetch request           -> o_ibus_rdt/ack
//   i_dbus_adr/dat/sel/we/cyc load/store request      -> o_dbus_rdt/ack
//   o_wb_adr/dat/sel/we/cyc   shared bus request
//   i_wb_rdt/ack              shared bus response
//   o_timeout                 one-cycle pulse on a timeout termination
// ---------------------------------------------------------------------------
module serv_mem_arb #(
  parameter RESET_STRATEGY = "MINI",
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // instruction fetch port
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  // load/store port
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  // shared bus
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  // status
  output logic        o_timeout
);

  // Counter must hold values 0..TIMEOUT-1; keep at least one bit so the
  // disabled configuration still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic TIMEOUT_EN = (TIMEOUT != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             last_d_r;   // 1: dbus was granted most recently
  logic [CNT_W-1:0] cnt_r;      // granted cycles seen without i_wb_ack

  logic             gnt_i_s;
  logic             gnt_d_s;
  logic             gnt_cyc_s;
  logic             expire_s;
  logic             done_s;
  logic             timeout_s;
  logic [31:0]      rdt_s;

  // Decode the current grant and the conditions that end a transaction.
  always_comb begin
    gnt_i_s = (state_r == GNT_I) ? 1'b1 : 1'b0;
    gnt_d_s = (state_r == GNT_D) ? 1'b1 : 1'b0;
    if (gnt_i_s) begin
      gnt_cyc_s = i_ibus_cyc;
    end else if (gnt_d_s) begin
      gnt_cyc_s = i_dbus_cyc;
    end else begin
      gnt_cyc_s = 1'b0;
    end
    // Expiry yields to a real bus ack arriving on the same cycle.
    expire_s  = TIMEOUT_EN & (gnt_i_s | gnt_d_s) & (cnt_r == CNT_LAST) & ~i_wb_ack;
    done_s    = gnt_cyc_s & (i_wb_ack | expire_s);
    // Only a still-requesting master is terminated by the timeout; an abort
    // landing on the expiry cycle is just an abort.
    timeout_s = gnt_cyc_s & expire_s;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_ibus_cyc && i_dbus_cyc) begin
          // Tie: hand the bus to whoever did not have it last.
          if (last_d_r) begin
            state_s = GNT_I;
          end else begin
            state_s = GNT_D;
          end
        end else if (i_ibus_cyc) begin
          state_s = GNT_I;
        end else if (i_dbus_cyc) begin
          state_s = GNT_D;
        end else begin
          state_s = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        // Completion (bus ack or timeout) and abort both release the bus.
        if (!gnt_cyc_s || done_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM outputs: bus cycle, request mux and per-master acks.
  always_comb begin
    o_wb_cyc   = gnt_cyc_s;
    o_ibus_ack = gnt_i_s & done_s;
    o_dbus_ack = gnt_d_s & done_s;
    o_timeout  = timeout_s;
    if (gnt_d_s) begin
      o_wb_adr = i_dbus_adr;
      o_wb_dat = i_dbus_dat;
      o_wb_sel = i_dbus_sel;
      o_wb_we  = i_dbus_we;
    end else begin
      // Fetches are always full-word reads.
      o_wb_adr = i_ibus_adr;
      o_wb_dat = 32'h0000_0000;
      o_wb_sel = 4'hf;
      o_wb_we  = 1'b0;
    end
  end

  // Last-grant register: records the winner each time a grant is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_d_r <= 1'b1;
    end else if ((state_r == IDLE) && (state_s != IDLE)) begin
      last_d_r <= (state_s == GNT_D) ? 1'b1 : 1'b0;
    end else begin
      last_d_r <= last_d_r;
    end
  end

  // Timeout counter: held at zero in IDLE so every grant starts from zero,
  // counts granted cycles without an ack, and saturates instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == IDLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!i_wb_ack && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Read data returned to both masters; forced to zero on a timeout.
  always_comb begin
    if (timeout_s) begin
      rdt_s = 32'h0000_0000;
    end else begin
      rdt_s = i_wb_rdt;
    end
  end

  // The read-data return is purely combinational, so no reset strategy
  // adds or removes state on it and every strategy uses the same steering.
  generate
    if (RESET_STRATEGY == "NONE") begin : g_rdt_noreset
      assign o_ibus_rdt = rdt_s;
      assign o_dbus_rdt = rdt_s;
    end else begin : g_rdt_reset
      assign o_ibus_rdt = rdt_s;
      assign o_dbus_rdt = rdt_s;
    end
  endgenerate

endmodule
